// File: rtl/lsu_split_access_if.sv
// Core-side request/response and data-bus signals of the load/store access unit.
// The slave modport is the unit's view; the master modport is the environment's view.
interface lsu_split_access_if #(
    parameter int XLEN = 32
);
    localparam int BW = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            bus_req;
    logic            bus_gnt;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [BW-1:0]   bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_err;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err,
        output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err,
        input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_split_access.sv
// Load/store access unit: lane placement, byte enables, read merge/extension,
// and splitting of word-crossing accesses into two sequential bus beats.
module lsu_split_access #(
    parameter int XLEN           = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_split_access_if.slave  lsu
);
    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam int IW = $clog2(XLEN);

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t            state_r, state_s;
    logic              we_r, uns_r, cross_r, err_r;
    logic [1:0]        size_r;
    logic [OW-1:0]     off_r;
    logic [XLEN-1:0]   base_r, wdata_r, r0_r, r1_r;

    logic [OW-1:0]     in_off_s;
    logic [3:0]        in_nbytes_s;
    logic              in_illegal_s, in_cross_s, in_reject_s;
    logic [3:0]        nbytes_s;
    logic [2*BW-1:0]   mask_s, be_wide_s;
    logic [2*XLEN-1:0] wd_wide_s, rd_wide_s;
    logic [XLEN-1:0]   addr1_s;

    logic              ready_s, bus_req_s, bus_we_s, rsp_valid_s, rsp_err_s;
    logic [XLEN-1:0]   bus_addr_s, bus_wdata_s, rsp_rdata_s;
    logic [BW-1:0]     bus_be_s;

    // Keep the low nbytes bytes of a merged read and sign- or zero-extend above them.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                    input logic [1:0] size,
                                                    input logic uns);
        logic [XLEN-1:0] res;
        logic [IW-1:0]   top;
        logic            fill;
        int              nbits;
        nbits = ((8 << size) > XLEN) ? XLEN : (8 << size);
        top   = IW'(nbits - 1);
        fill  = d[top] & ~uns;
        for (int i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? d[i] : fill;
        end
        return res;
    endfunction

    assign in_off_s     = lsu.req_addr[OW-1:0];
    assign in_nbytes_s  = 4'd1 << lsu.req_size;
    assign in_illegal_s = (XLEN == 32) && (lsu.req_size == 2'd3);
    assign in_cross_s   = (32'(in_off_s) + 32'(in_nbytes_s)) > 32'(BW);
    assign in_reject_s  = in_illegal_s || (in_cross_s && !ALLOW_MISALIGN);

    // Both beats come from one double-width shift; the upper half is beat 1.
    assign nbytes_s  = 4'd1 << size_r;
    assign mask_s    = (2*BW)'(8'hFF >> (4'd8 - nbytes_s));
    assign be_wide_s = mask_s << off_r;
    assign wd_wide_s = {{XLEN{1'b0}}, wdata_r} << {off_r, 3'b000};
    assign rd_wide_s = {r1_r, r0_r} >> {off_r, 3'b000};
    assign addr1_s   = base_r + XLEN'(BW);

    // State register and per-access datapath capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            cross_r <= 1'b0;
            err_r   <= 1'b0;
            size_r  <= 2'd0;
            off_r   <= '0;
            base_r  <= '0;
            wdata_r <= '0;
            r0_r    <= '0;
            r1_r    <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (lsu.req_valid) begin
                        we_r    <= lsu.req_we;
                        uns_r   <= lsu.req_unsigned;
                        size_r  <= lsu.req_size;
                        off_r   <= in_off_s;
                        base_r  <= {lsu.req_addr[XLEN-1:OW], {OW{1'b0}}};
                        wdata_r <= lsu.req_wdata;
                        cross_r <= in_cross_s;
                        err_r   <= in_reject_s;
                        r0_r    <= '0;
                        r1_r    <= '0;
                    end
                end
                WAIT0: begin
                    if (lsu.bus_rvalid) begin
                        r0_r  <= lsu.bus_rdata;
                        err_r <= lsu.bus_err;
                    end
                end
                WAIT1: begin
                    if (lsu.bus_rvalid) begin
                        r1_r  <= lsu.bus_rdata;
                        err_r <= err_r | lsu.bus_err;
                    end
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_s     = state_r;
        ready_s     = 1'b0;
        bus_req_s   = 1'b0;
        bus_we_s    = 1'b0;
        bus_addr_s  = '0;
        bus_be_s    = '0;
        bus_wdata_s = '0;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_rdata_s = '0;
        case (state_r)
            IDLE: begin
                ready_s = 1'b1;
                if (lsu.req_valid) begin
                    state_s = in_reject_s ? RESP : REQ0;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ0: begin
                bus_req_s   = 1'b1;
                bus_we_s    = we_r;
                bus_addr_s  = base_r;
                bus_be_s    = be_wide_s[BW-1:0];
                bus_wdata_s = wd_wide_s[XLEN-1:0];
                state_s     = lsu.bus_gnt ? WAIT0 : REQ0;
            end
            WAIT0: begin
                if (!lsu.bus_rvalid) begin
                    state_s = WAIT0;
                end else if (lsu.bus_err || !cross_r) begin
                    state_s = RESP;
                end else begin
                    state_s = REQ1;
                end
            end
            REQ1: begin
                bus_req_s   = 1'b1;
                bus_we_s    = we_r;
                bus_addr_s  = addr1_s;
                bus_be_s    = be_wide_s[2*BW-1:BW];
                bus_wdata_s = wd_wide_s[2*XLEN-1:XLEN];
                state_s     = lsu.bus_gnt ? WAIT1 : REQ1;
            end
            WAIT1: begin
                state_s = lsu.bus_rvalid ? RESP : WAIT1;
            end
            RESP: begin
                rsp_valid_s = 1'b1;
                rsp_err_s   = err_r;
                if (we_r || err_r) begin
                    rsp_rdata_s = '0;
                end else begin
                    rsp_rdata_s = extend_load(rd_wide_s[XLEN-1:0], size_r, uns_r);
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Everything is forced low while reset is asserted, including the cycle it first appears.
    assign lsu.req_ready = rst_n & ready_s;
    assign lsu.bus_req   = rst_n & bus_req_s;
    assign lsu.bus_we    = rst_n & bus_we_s;
    assign lsu.bus_addr  = rst_n ? bus_addr_s  : '0;
    assign lsu.bus_be    = rst_n ? bus_be_s    : '0;
    assign lsu.bus_wdata = rst_n ? bus_wdata_s : '0;
    assign lsu.rsp_valid = rst_n & rsp_valid_s;
    assign lsu.rsp_err   = rst_n & rsp_err_s;
    assign lsu.rsp_rdata = rst_n ? rsp_rdata_s : '0;
endmodule
